mmul_stream_driver: RTL and testbench

- Host-side counterpart of the systolic matrix-multiply accelerator top.
- Holds a weight matrix and an activation matrix in local register files and transmits them as an AXI4-Stream master into the accelerator's slave port. It drives `load_weight` during the weight phase and appends flush beats.
- Receives the accelerator's master output stream, discards pipeline-fill beats, and stores valid result rows in a readable result buffer.

---
 rtl/mmul_stream_driver.sv | 161 ++++++++++++++++
 tb/tb_mmul_stream_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_stream_driver.sv
// mmul_stream_driver
//   Host-side driver for the systolic matrix-multiply accelerator.
//   Holds weight rows and activation rows in local register files and
//   streams them to the accelerator: N weight rows in reverse order with
//   load_weight high, then M activation rows, then PIPE_BEATS zero beats
//   to push the last activations through the array. In parallel it accepts
//   the accelerator's result stream, skips the pipeline-fill beats and
//   stores the M useful result rows in a readable buffer.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   wr_en/wr_sel/     local buffer write (weights: sel=0, activations:
//   wr_addr/wr_data   sel=1); ignored while busy
//   start, cfg_rows   launch a run of cfg_rows activation rows
//   busy, done        run in progress / one-cycle completion pulse
//   load_weight       weight-phase flag to the accelerator
//   m_axis_*          AXI4-Stream master toward the accelerator
//   s_axis_*          AXI4-Stream slave from the accelerator
//   rd_addr, rd_data  combinational read of the result buffer
module mmul_stream_driver #(
    parameter int N            = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32,
    parameter int MAX_ROWS     = 16,
    parameter int RAW          = $clog2(MAX_ROWS),
    parameter int PIPE_BEATS   = 2 * N
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [RAW-1:0]               wr_addr,
    input  logic [N*DATA_WIDTH-1:0]      wr_data,
    input  logic                         start,
    input  logic [RAW:0]                 cfg_rows,
    output logic                         busy,
    output logic                         done,
    output logic                         load_weight,
    output logic [N*DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    input  logic [N*RESULT_WIDTH-1:0]    s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [RAW-1:0]               rd_addr,
    output logic [N*RESULT_WIDTH-1:0]    rd_data
);
    // Counter width covers the full output-beat total N+MAX_ROWS+PIPE_BEATS.
    localparam int CW   = $clog2(N + MAX_ROWS + PIPE_BEATS) + 1;
    localparam int NW   = (N > 1) ? $clog2(N) : 1;
    localparam int AW   = N * DATA_WIDTH;
    localparam int RW   = N * RESULT_WIDTH;
    // First output beat that carries a real result row.
    localparam logic [CW-1:0] BASE = CW'(N + PIPE_BEATS);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, STREAM, FLUSH, DRAIN, DONE
    } state_t;

    state_t          state, nxt;
    logic [AW-1:0]   wbuf [N];
    logic [AW-1:0]   abuf [MAX_ROWS];
    logic [RW-1:0]   rbuf [MAX_ROWS];
    logic [RAW:0]    m_rows;
    logic [CW-1:0]   ti;          // transmit index within current phase
    logic [CW-1:0]   oc;          // receive beat counter for the whole run
    logic [CW-1:0]   phase_len;
    logic [CW-1:0]   total;
    logic            tx_beat, rx_beat, tx_last, start_ok, in_window;

    assign tx_beat   = m_axis_tvalid && m_axis_tready;
    assign rx_beat   = s_axis_tvalid && s_axis_tready;
    assign start_ok  = (state == IDLE) && start && (cfg_rows != '0) &&
                       (cfg_rows <= (RAW+1)'(MAX_ROWS));
    assign total     = BASE + CW'(m_rows);
    assign in_window = (oc >= BASE) && (oc < total);
    assign tx_last   = tx_beat && (ti == phase_len - CW'(1));

    always_comb begin
        phase_len = CW'(1);
        case (state)
            LOAD_W:  phase_len = CW'(N);
            STREAM:  phase_len = CW'(m_rows);
            FLUSH:   phase_len = CW'(PIPE_BEATS);
            default: phase_len = CW'(1);
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start_ok) nxt = LOAD_W;
            LOAD_W:  if (tx_last)  nxt = STREAM;
            STREAM:  if (tx_last)  nxt = FLUSH;
            FLUSH:   if (tx_last)  nxt = DRAIN;
            // oc may already be complete on entry; then DRAIN lasts one cycle.
            DRAIN:   if (oc >= total) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // FSM with outputs registered from the next-state decode, so every
    // handshake output lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            load_weight   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            ti            <= '0;
            oc            <= '0;
            m_rows        <= '0;
        end else begin
            state         <= nxt;
            busy          <= (nxt != IDLE);
            done          <= (nxt == DONE);
            load_weight   <= (nxt == LOAD_W);
            m_axis_tvalid <= (nxt == LOAD_W) || (nxt == STREAM) || (nxt == FLUSH);
            s_axis_tready <= (nxt == LOAD_W) || (nxt == STREAM) ||
                             (nxt == FLUSH)  || (nxt == DRAIN);
            if (start_ok) begin
                m_rows <= cfg_rows;
                ti     <= '0;
                oc     <= '0;
            end else begin
                if (tx_last)      ti <= '0;
                else if (tx_beat) ti <= ti + CW'(1);
                if (rx_beat)      oc <= oc + CW'(1);
            end
        end
    end

    // Storage is deliberately not reset; stale result rows stay readable.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            if (!wr_sel) begin
                if (wr_addr < RAW'(N)) wbuf[wr_addr[NW-1:0]] <= wr_data;
            end else begin
                abuf[wr_addr] <= wr_data;
            end
        end
        if (rx_beat && in_window)
            rbuf[RAW'(oc - BASE)] <= s_axis_tdata;
    end

    // Weights go out last row first so row 0 ends up nearest the array edge.
    always_comb begin
        m_axis_tdata = '0;
        case (state)
            LOAD_W:  m_axis_tdata = wbuf[NW'(N-1) - ti[NW-1:0]];
            STREAM:  m_axis_tdata = abuf[ti[RAW-1:0]];
            default: m_axis_tdata = '0;
        endcase
    end

    assign rd_data = rbuf[rd_addr];

endmodule

// File: tb/tb_mmul_stream_driver.sv
module tb_mmul_stream_driver;
    localparam int N = 4, DW = 8, RW = 32, MAXR = 16, RAW = 4, PB = 2 * N;

    logic                 clk = 1'b0, reset = 1'b0;
    logic                 wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [RAW-1:0]       wr_addr = '0, rd_addr = '0;
    logic [N*DW-1:0]      wr_data = '0;
    logic [RAW:0]         cfg_rows = '0;
    logic                 busy, done, load_weight, m_axis_tvalid, s_axis_tready;
    logic [N*DW-1:0]      m_axis_tdata;
    logic                 m_axis_tready = 1'b0, s_axis_tvalid = 1'b0;
    logic [N*RW-1:0]      s_axis_tdata = '0, rd_data;

    mmul_stream_driver dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .cfg_rows(cfg_rows),
        .busy(busy), .done(done), .load_weight(load_weight),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [N*DW-1:0] d; logic lw; } beat_t;

    int n_cmp = 0, n_bad = 0;
    beat_t           exp_tx[$];
    logic [N*DW-1:0] tx_log[$];
    logic [N*DW-1:0] w_m [N];
    logic [N*DW-1:0] a_m [MAXR];
    logic [N*RW-1:0] res_m [MAXR];
    bit              res_known [MAXR];
    logic [N*RW-1:0] rx_d [N+MAXR+PB];
    bit chk_en = 0, in_run = 0;
    int done_cnt = 0, rx_cnt = 0, rx_total = 0, lw_beats = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result of one activation row: y[j] = sum_i a[i]*W[i][j].
    function automatic logic [N*RW-1:0] mm(logic [N*DW-1:0] a);
        logic [N*RW-1:0] y = '0;
        for (int j = 0; j < N; j++) begin
            logic [RW-1:0] s = '0;
            for (int i = 0; i < N; i++)
                s += RW'(a[i*DW +: DW]) * RW'(w_m[i][j*DW +: DW]);
            y[j*RW +: RW] = s;
        end
        return y;
    endfunction

    // Per-cycle compare against the expected transmit sequence and run window.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_axis_tvalid) begin
                if (exp_tx.size() == 0) chk("tx_extra_beat", 1, 0);
                else begin
                    chk("tx_data", m_axis_tdata, exp_tx[0].d);
                    chk("tx_load_weight", load_weight, exp_tx[0].lw);
                    if (m_axis_tready) begin
                        tx_log.push_back(m_axis_tdata);
                        if (load_weight) lw_beats++;
                        void'(exp_tx.pop_front());
                    end
                end
            end else begin
                chk("lw_without_valid", load_weight, 0);
                if (in_run && exp_tx.size() != 0) chk("tx_valid_gap", 0, 1);
            end
            if (s_axis_tvalid && s_axis_tready) rx_cnt++;
            if (in_run) begin
                chk("busy_run", busy, 1);
                if (!done) chk("rx_ready_run", s_axis_tready, 1);
            end else begin
                chk("busy_idle", busy, 0);
                chk("valid_idle", m_axis_tvalid, 0);
                chk("done_idle", done, 0);
            end
            if (done) begin
                done_cnt++;
                chk("done_after_all_beats", {exp_tx.size() == 0, rx_cnt == rx_total}, 2'b11);
                chk("rx_ready_done", s_axis_tready, 0);
                in_run = 0;
            end
        end
    end

    task automatic wr(bit sel, int addr, logic [N*DW-1:0] d);
        @(posedge clk); #1;
        wr_en = 1; wr_sel = sel; wr_addr = RAW'(addr); wr_data = d;
        @(posedge clk); #1;
        wr_en = 0;
    endtask

    task automatic drive(bit stall);
        m_axis_tready = stall ? ($urandom_range(2) != 0) : 1'b1;
        s_axis_tvalid = (rx_cnt < rx_total) && (stall ? $urandom_range(1) == 1 : 1'b1);
        s_axis_tdata  = (rx_cnt < rx_total) ? rx_d[rx_cnt] : '0;
    endtask

    task automatic check_rows();
        for (int r = 0; r < MAXR; r++) if (res_known[r]) begin
            rd_addr = RAW'(r); #1;
            chk($sformatf("result_row%0d", r), rd_data, res_m[r]);
        end
    endtask

    // mode: 0 random, 1 identity W with ramp activations, 2 all-ones
    task automatic run(int m, bit stall, int mode, bit wr_at_start, bit poke);
        logic [N*DW-1:0] row0;
        int d0, total;
        for (int i = 0; i < N; i++) begin
            w_m[i] = (mode == 1) ? (32'h1 << (i*DW)) : (mode == 2) ? 32'h01010101 : $urandom;
            wr(0, i, w_m[i]);
        end
        for (int r = 0; r < m; r++) begin
            a_m[r] = (mode == 1) ? {8'(r+4), 8'(r+3), 8'(r+2), 8'(r+1)} :
                     (mode == 2) ? 32'h01010101 : $urandom;
            wr(1, r, a_m[r]);
        end
        row0 = $urandom;
        if (wr_at_start) a_m[0] = row0;
        for (int j = 0; j < N; j++) exp_tx.push_back('{w_m[N-1-j], 1'b1});
        for (int r = 0; r < m; r++) exp_tx.push_back('{a_m[r], 1'b0});
        for (int k = 0; k < PB; k++) exp_tx.push_back('{'0, 1'b0});
        total = N + m + PB;
        for (int b = 0; b < total; b++)
            rx_d[b] = (b >= N + PB) ? mm(a_m[b-N-PB]) : {$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        @(posedge clk); #1;
        rx_cnt = 0; rx_total = total;
        start = 1; cfg_rows = (RAW+1)'(m);
        if (wr_at_start) begin wr_en = 1; wr_sel = 1; wr_addr = '0; wr_data = row0; end
        drive(stall);
        @(posedge clk); #1;
        start = 0; wr_en = 0; in_run = 1;
        drive(stall);
        for (int c = 0; c < 600 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
            if (poke && c == 3) begin
                start = 1; cfg_rows = 5'd2;
                wr_en = 1; wr_sel = 1; wr_addr = '0; wr_data = 32'hDEADBEEF;
            end else begin
                start = 0; wr_en = 0;
            end
            drive(stall);
        end
        start = 0; wr_en = 0;
        if (done_cnt == d0) chk("run_timeout", 0, 1);
        s_axis_tvalid = 0; m_axis_tready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("tx_all_sent", exp_tx.size(), 0);
        exp_tx.delete(); in_run = 0;
        for (int r = 0; r < m; r++) begin res_m[r] = rx_d[N+PB+r]; res_known[r] = 1; end
        check_rows();
    endtask

    initial begin
        for (int r = 0; r < MAXR; r++) res_known[r] = 0;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_lw", load_weight, 0);
        chk("rst_tvalid", m_axis_tvalid, 0); chk("rst_tready", s_axis_tready, 0);
        @(posedge clk); #1; reset = 1; chk_en = 1;

        // identity weights, ramp activations, no stalls; pin model with literals
        tx_log.delete(); lw_beats = 0;
        run(4, 0, 1, 0, 0);
        chk("beat0_is_W3", tx_log[0], 32'h01000000);
        chk("beat3_is_W0", tx_log[3], 32'h00000001);
        chk("beat4_is_A0", tx_log[4], 32'h04030201);
        chk("beat7_is_A3", tx_log[7], 32'h07060504);
        chk("beat_count", tx_log.size(), 16);
        chk("lw_beats", lw_beats, 4);
        rd_addr = 4'd0; #1; chk("lit_row0", rd_data, 128'h00000004_00000003_00000002_00000001);
        rd_addr = 4'd3; #1; chk("lit_row3", rd_data, 128'h00000007_00000006_00000005_00000004);

        // same data with random backpressure on both streams
        run(4, 1, 1, 0, 0);

        // illegal row counts are ignored
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1; start = 1; cfg_rows = (k == 0) ? 5'd0 : 5'd17;
            @(posedge clk); #1; start = 0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bad_cfg_busy", busy, 0); chk("bad_cfg_tvalid", m_axis_tvalid, 0);
        end

        // random runs: mid-run start/write pokes, start+write same cycle
        for (int k = 0; k < 6; k++)
            run($urandom_range(MAXR, 1), 1, 0, k == 2, k % 2 == 0);

        // reset during the stream phase aborts at once
        chk_en = 0;
        @(posedge clk); #1; start = 1; cfg_rows = 5'd4; m_axis_tready = 1; s_axis_tvalid = 0;
        @(posedge clk); #1; start = 0;
        repeat (6) @(posedge clk);
        #1; reset = 0;
        @(posedge clk); #1; reset = 1;
        @(negedge clk);
        chk("abort_tvalid", m_axis_tvalid, 0); chk("abort_lw", load_weight, 0);
        chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        exp_tx.delete(); tx_log.delete(); chk_en = 1;
        run(1, 0, 0, 0, 0);

        // full depth, all-ones weights and activations
        run(16, 0, 2, 0, 0);
        rd_addr = 4'd15; #1; chk("lit_row15", rd_data, 128'h00000004_00000004_00000004_00000004);
        rd_addr = 4'd0;  #1; chk("lit_row0_ones", rd_data, 128'h00000004_00000004_00000004_00000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
